alu_issue: RTL and testbench

ID/EX issue stage of the pipelined MIPS core: the producing side of the ALU interface. It decodes the ID-stage instruction into an ALU opsel word, selects and forwards operands, detects load-use hazards, and holds everything in the ID/EX pipeline register that drives the ALU, `op_a`, `op_b` and `alu_opsel`, plus the downstream control bits.

---
 rtl/alu_issue_pkg.sv | 93 +++++++++
 rtl/alu_issue_ctrl_dec.sv | 90 +++++++++
 rtl/alu_issue.sv | 143 ++++++++++++++
 tb/tb_alu_issue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions for the ID/EX issue stage.
// Holds the opsel encoding, the MIPS opcode/funct constants and the decode record.
package alu_issue_pkg;

  localparam int unsigned REG_WIDTH       = 32;
  localparam int unsigned ALU_OPSEL_WIDTH = 5;

  // opsel layout: [4:3] class, [2:0] sub-op
  localparam int unsigned OPSEL_CLS_MSB = 4;
  localparam int unsigned OPSEL_CLS_LSB = 3;
  localparam int unsigned OPSEL_SUB_MSB = 2;
  localparam int unsigned OPSEL_SUB_LSB = 0;

  typedef enum logic [1:0] {
    CLS_SHIFT = 2'b00,
    CLS_ARITH = 2'b01,
    CLS_LOGIC = 2'b10
  } alu_class_e;

  localparam logic [2:0] SUB_SLL  = 3'b000;
  localparam logic [2:0] SUB_SRL  = 3'b001;
  localparam logic [2:0] SUB_SRA  = 3'b010;
  localparam logic [2:0] SUB_ADD  = 3'b000;
  localparam logic [2:0] SUB_ADDU = 3'b001;
  localparam logic [2:0] SUB_SUB  = 3'b010;
  localparam logic [2:0] SUB_SUBU = 3'b011;
  localparam logic [2:0] SUB_SLT  = 3'b100;
  localparam logic [2:0] SUB_SLTU = 3'b101;
  localparam logic [2:0] SUB_AND  = 3'b000;
  localparam logic [2:0] SUB_OR   = 3'b001;
  localparam logic [2:0] SUB_XOR  = 3'b010;
  localparam logic [2:0] SUB_NOR  = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {OPA_RS, OPA_RT, OPA_IMM} opa_sel_e;
  typedef enum logic [2:0] {OPB_RT, OPB_RS, OPB_SHAMT, OPB_IMM, OPB_SIXTEEN} opb_sel_e;
  typedef enum logic {EXT_SIGN, EXT_ZERO} imm_ext_e;
  typedef enum logic {DST_RD, DST_RT} dst_sel_e;
  typedef enum logic {ST_EMPTY, ST_FULL} stage_e;

  typedef struct packed {
    logic [4:0]  opsel;
    opa_sel_e    opa_sel;
    opb_sel_e    opb_sel;
    imm_ext_e    imm_ext;
    dst_sel_e    dst_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        rt_read;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } alu_dec_t;

  function automatic logic [4:0] mk_opsel(input alu_class_e cls, input logic [2:0] sub);
    return {cls, sub};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_dec.sv
// Combinational instruction decoder: opsel, operand sources, immediate kind,
// destination select and control bits for the ID/EX issue stage.
module alu_ctrl_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] id_instr,
  output alu_dec_t    dec
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];

  always_comb begin
    dec           = '0;
    dec.opa_sel   = OPA_RS;
    dec.opb_sel   = OPB_IMM;
    dec.imm_ext   = EXT_SIGN;
    dec.dst_sel   = DST_RT;
    dec.rs        = id_instr[25:21];
    dec.rt        = id_instr[20:16];
    dec.rd        = id_instr[15:11];
    dec.shamt     = id_instr[10:6];
    dec.imm       = id_instr[15:0];
    dec.reg_write = 1'b1;

    unique case (opcode)
      OP_RTYPE: begin
        dec.dst_sel = DST_RD;
        dec.rt_read = 1'b1;
        dec.opb_sel = OPB_RT;
        unique case (funct)
          FN_SLL:  begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SLL); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_SHAMT; end
          FN_SRL:  begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SRL); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_SHAMT; end
          FN_SRA:  begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SRA); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_SHAMT; end
          FN_SLLV: begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SLL); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_RS; end
          FN_SRLV: begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SRL); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_RS; end
          FN_SRAV: begin dec.opsel = mk_opsel(CLS_SHIFT, SUB_SRA); dec.opa_sel = OPA_RT; dec.opb_sel = OPB_RS; end
          FN_ADD:  dec.opsel = mk_opsel(CLS_ARITH, SUB_ADD);
          FN_ADDU: dec.opsel = mk_opsel(CLS_ARITH, SUB_ADDU);
          FN_SUB:  dec.opsel = mk_opsel(CLS_ARITH, SUB_SUB);
          FN_SUBU: dec.opsel = mk_opsel(CLS_ARITH, SUB_SUBU);
          FN_SLT:  dec.opsel = mk_opsel(CLS_ARITH, SUB_SLT);
          FN_SLTU: dec.opsel = mk_opsel(CLS_ARITH, SUB_SLTU);
          FN_AND:  dec.opsel = mk_opsel(CLS_LOGIC, SUB_AND);
          FN_OR:   dec.opsel = mk_opsel(CLS_LOGIC, SUB_OR);
          FN_XOR:  dec.opsel = mk_opsel(CLS_LOGIC, SUB_XOR);
          FN_NOR:  dec.opsel = mk_opsel(CLS_LOGIC, SUB_NOR);
          default: begin dec.illegal = 1'b1; dec.reg_write = 1'b0; end
        endcase
      end
      OP_ADDI:  dec.opsel = mk_opsel(CLS_ARITH, SUB_ADD);
      OP_ADDIU: dec.opsel = mk_opsel(CLS_ARITH, SUB_ADDU);
      OP_SLTI:  dec.opsel = mk_opsel(CLS_ARITH, SUB_SLT);
      OP_SLTIU: dec.opsel = mk_opsel(CLS_ARITH, SUB_SLTU);
      OP_ANDI:  begin dec.opsel = mk_opsel(CLS_LOGIC, SUB_AND); dec.imm_ext = EXT_ZERO; end
      OP_ORI:   begin dec.opsel = mk_opsel(CLS_LOGIC, SUB_OR);  dec.imm_ext = EXT_ZERO; end
      OP_XORI:  begin dec.opsel = mk_opsel(CLS_LOGIC, SUB_XOR); dec.imm_ext = EXT_ZERO; end
      // lui becomes imm16 << 16 through the shifter
      OP_LUI: begin
        dec.opsel   = mk_opsel(CLS_SHIFT, SUB_SLL);
        dec.opa_sel = OPA_IMM;
        dec.opb_sel = OPB_SIXTEEN;
      end
      OP_LW: begin
        dec.opsel    = mk_opsel(CLS_ARITH, SUB_ADD);
        dec.mem_read = 1'b1;
      end
      OP_SW: begin
        dec.opsel     = mk_opsel(CLS_ARITH, SUB_ADD);
        dec.mem_write = 1'b1;
        dec.reg_write = 1'b0;
        dec.rt_read   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.opsel     = mk_opsel(CLS_ARITH, SUB_SUBU);
        dec.opb_sel   = OPB_RT;
        dec.reg_write = 1'b0;
        dec.rt_read   = 1'b1;
      end
      default: begin
        dec.illegal   = 1'b1;
        dec.reg_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: operand forwarding, load-use hazard detection and the
// ID/EX pipeline register that feeds the ALU.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned REG_WIDTH       = alu_issue_pkg::REG_WIDTH,
  parameter int unsigned ALU_OPSEL_WIDTH = alu_issue_pkg::ALU_OPSEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [31:0]                id_instr,
  input  logic [REG_WIDTH-1:0]       id_rs_data,
  input  logic [REG_WIDTH-1:0]       id_rt_data,
  input  logic                       ex_ready,
  input  logic                       flush,
  input  logic                       exm_wr,
  input  logic [4:0]                 exm_dst,
  input  logic [REG_WIDTH-1:0]       exm_data,
  input  logic                       mwb_wr,
  input  logic [4:0]                 mwb_dst,
  input  logic [REG_WIDTH-1:0]       mwb_data,
  output logic                       id_stall,
  output logic                       ex_valid,
  output logic [REG_WIDTH-1:0]       op_a,
  output logic [REG_WIDTH-1:0]       op_b,
  output logic [ALU_OPSEL_WIDTH-1:0] alu_opsel,
  output logic [4:0]                 ex_dst,
  output logic                       ex_reg_write,
  output logic                       ex_mem_read,
  output logic                       ex_mem_write,
  output logic [REG_WIDTH-1:0]       ex_store_data,
  output logic                       ex_illegal
);

  alu_dec_t dec;

  alu_ctrl_dec u_dec (
    .id_instr (id_instr),
    .dec      (dec)
  );

  logic [REG_WIDTH-1:0] rs_fwd, rt_fwd, imm_ext, imm_zext;
  logic [REG_WIDTH-1:0] op_a_d, op_b_d;
  logic [4:0]           dst_d;

  // r0 is hard-wired to zero, so it never takes a forwarded value
  always_comb begin
    rs_fwd = id_rs_data;
    if (dec.rs == 5'd0)                     rs_fwd = '0;
    else if (exm_wr && exm_dst == dec.rs)   rs_fwd = exm_data;
    else if (mwb_wr && mwb_dst == dec.rs)   rs_fwd = mwb_data;

    rt_fwd = id_rt_data;
    if (dec.rt == 5'd0)                     rt_fwd = '0;
    else if (exm_wr && exm_dst == dec.rt)   rt_fwd = exm_data;
    else if (mwb_wr && mwb_dst == dec.rt)   rt_fwd = mwb_data;
  end

  assign imm_zext = {{(REG_WIDTH-16){1'b0}}, dec.imm};
  assign imm_ext  = (dec.imm_ext == EXT_ZERO) ? imm_zext
                                              : {{(REG_WIDTH-16){dec.imm[15]}}, dec.imm};
  assign dst_d    = (dec.dst_sel == DST_RD) ? dec.rd : dec.rt;

  always_comb begin
    op_a_d = rs_fwd;
    unique case (dec.opa_sel)
      OPA_RT:  op_a_d = rt_fwd;
      OPA_IMM: op_a_d = imm_zext;
      default: op_a_d = rs_fwd;
    endcase

    op_b_d = imm_ext;
    unique case (dec.opb_sel)
      OPB_RT:      op_b_d = rt_fwd;
      OPB_RS:      op_b_d = rs_fwd;
      OPB_SHAMT:   op_b_d = REG_WIDTH'(dec.shamt);
      OPB_SIXTEEN: op_b_d = REG_WIDTH'(16);
      default:     op_b_d = imm_ext;
    endcase
  end

  stage_e                     state_q;
  logic [REG_WIDTH-1:0]       op_a_q, op_b_q, store_q;
  logic [ALU_OPSEL_WIDTH-1:0] opsel_q;
  logic [4:0]                 dst_q;
  logic                       reg_write_q, mem_read_q, mem_write_q, illegal_q;

  assign ex_valid      = (state_q == ST_FULL);
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign alu_opsel     = opsel_q;
  assign ex_dst        = dst_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_store_data = store_q;
  assign ex_illegal    = illegal_q;

  assign id_stall = id_valid && ex_valid && mem_read_q && (dst_q != 5'd0) &&
                    ((dst_q == dec.rs) || (dec.rt_read && dst_q == dec.rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      op_a_q      <= '0;
      op_b_q      <= '0;
      store_q     <= '0;
      opsel_q     <= '0;
      dst_q       <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (ex_ready) begin
      if (flush || id_stall || !id_valid || dec.illegal) begin
        // a killed or stalled slot never reports illegal; only a real issue attempt does
        state_q     <= ST_EMPTY;
        op_a_q      <= '0;
        op_b_q      <= '0;
        store_q     <= '0;
        opsel_q     <= '0;
        dst_q       <= '0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        illegal_q   <= id_valid && !flush && !id_stall && dec.illegal;
      end else begin
        state_q     <= ST_FULL;
        op_a_q      <= op_a_d;
        op_b_q      <= op_b_d;
        store_q     <= rt_fwd;
        opsel_q     <= ALU_OPSEL_WIDTH'(dec.opsel);
        dst_q       <= dst_d;
        reg_write_q <= dec.reg_write && (dst_d != 5'd0);
        mem_read_q  <= dec.mem_read;
        mem_write_q <= dec.mem_write;
        illegal_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with hand-computed expectations.
module tb_alu_issue;

  logic        clk, rst;
  logic        id_valid, ex_ready, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        exm_wr, mwb_wr;
  logic [4:0]  exm_dst, mwb_dst;
  logic [31:0] exm_data, mwb_data;
  logic        id_stall, ex_valid;
  logic [31:0] op_a, op_b, ex_store_data;
  logic [4:0]  alu_opsel, ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  alu_issue #(.REG_WIDTH(32), .ALU_OPSEL_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .ex_ready      (ex_ready),
    .flush         (flush),
    .exm_wr        (exm_wr),
    .exm_dst       (exm_dst),
    .exm_data      (exm_data),
    .mwb_wr        (mwb_wr),
    .mwb_dst       (mwb_dst),
    .mwb_data      (mwb_data),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .op_a          (op_a),
    .op_b          (op_b),
    .alu_opsel     (alu_opsel),
    .ex_dst        (ex_dst),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_store_data (ex_store_data),
    .ex_illegal    (ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
    id_instr = '0; id_rs_data = '0; id_rt_data = '0;
    exm_wr = 1'b0; exm_dst = '0; exm_data = '0;
    mwb_wr = 1'b0; mwb_dst = '0; mwb_data = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_op_b", op_b, 32'h0);
    chk("rst_opsel", 32'(alu_opsel), 32'h0);
    chk("rst_ctrl", {29'h0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'h0);
    chk("rst_stall", 32'(id_stall), 32'h0);
    chk("rst_illegal", 32'(ex_illegal), 32'h0);

    // addu r3, r1, r2
    id_valid = 1'b1; ex_ready = 1'b1;
    id_rs_data = 32'd5; id_rt_data = 32'd7;
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    #9 rst = 1'b0;
    step;
    chk("addu_valid", 32'(ex_valid), 32'h1);
    chk("addu_op_a", op_a, 32'd5);
    chk("addu_op_b", op_b, 32'd7);
    chk("addu_opsel", 32'(alu_opsel), 32'b01001);
    chk("addu_dst", 32'(ex_dst), 32'd3);
    chk("addu_wr", 32'(ex_reg_write), 32'h1);

    id_instr = i_ins(6'h08, 5'd1, 5'd4, 16'hFFFF);
    step;
    chk("addi_op_b", op_b, 32'hFFFF_FFFF);
    chk("addi_opsel", 32'(alu_opsel), 32'b01000);
    chk("addi_dst", 32'(ex_dst), 32'd4);

    id_instr = i_ins(6'h0D, 5'd1, 5'd4, 16'hFFFF);
    step;
    chk("ori_op_b", op_b, 32'h0000_FFFF);
    chk("ori_opsel", 32'(alu_opsel), 32'b10001);

    id_instr = i_ins(6'h0F, 5'd0, 5'd6, 16'h1234);
    step;
    chk("lui_opsel", 32'(alu_opsel), 32'b00000);
    chk("lui_op_a", op_a, 32'h1234);
    chk("lui_op_b", op_b, 32'd16);

    // srav r7, r2(=7), r1(=5): op_a = rt, op_b = rs
    id_instr = r_ins(5'd1, 5'd2, 5'd7, 5'd0, 6'h07);
    step;
    chk("srav_op_a", op_a, 32'd7);
    chk("srav_op_b", op_b, 32'd5);
    chk("srav_opsel", 32'(alu_opsel), 32'b00010);

    id_instr = r_ins(5'd0, 5'd2, 5'd9, 5'd3, 6'h00);
    step;
    chk("sll_op_b", op_b, 32'd3);

    // both forward sources target r1: EX/MEM must win
    exm_wr = 1'b1; exm_dst = 5'd1; exm_data = 32'hAA;
    mwb_wr = 1'b1; mwb_dst = 5'd1; mwb_data = 32'hBB;
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    chk("fwd_prio_a", op_a, 32'hAA);
    chk("fwd_prio_b", op_b, 32'd7);

    exm_dst = 5'd0; mwb_dst = 5'd0; id_rs_data = 32'd0;
    id_instr = r_ins(5'd0, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    chk("fwd_r0_a", op_a, 32'h0);

    id_rs_data = 32'd5;
    exm_dst = 5'd9; mwb_dst = 5'd2;
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    chk("fwd_mwb_b", op_b, 32'hBB);
    chk("fwd_mwb_a", op_a, 32'd5);
    exm_wr = 1'b0; mwb_wr = 1'b0;

    id_instr = r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h21);
    step;
    chk("dst0_wr", 32'(ex_reg_write), 32'h0);
    chk("dst0_valid", 32'(ex_valid), 32'h1);

    id_instr = i_ins(6'h2B, 5'd1, 5'd2, 16'h0008);
    step;
    chk("sw_ctrl", {29'h0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b001);
    chk("sw_store", ex_store_data, 32'd7);
    chk("sw_op_b", op_b, 32'd8);

    id_instr = i_ins(6'h04, 5'd1, 5'd2, 16'h0003);
    step;
    chk("beq_opsel", 32'(alu_opsel), 32'b01011);
    chk("beq_op_b", op_b, 32'd7);
    chk("beq_wr", 32'(ex_reg_write), 32'h0);

    // load-use: lw r5, then a consumer of r5
    id_instr = i_ins(6'h23, 5'd1, 5'd5, 16'h0004);
    step;
    chk("lw_ctrl", {29'h0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b110);
    chk("lw_dst", 32'(ex_dst), 32'd5);
    id_instr = i_ins(6'h08, 5'd1, 5'd5, 16'h0001);
    #1;
    chk("nostall_rt_unread", 32'(id_stall), 32'h0);
    id_instr = r_ins(5'd5, 5'd2, 5'd8, 5'd0, 6'h21);
    #1;
    chk("stall_on", 32'(id_stall), 32'h1);
    step;
    chk("stall_bubble", 32'(ex_valid), 32'h0);
    chk("stall_bubble_wr", 32'(ex_reg_write), 32'h0);
    chk("stall_off", 32'(id_stall), 32'h0);
    exm_wr = 1'b1; exm_dst = 5'd5; exm_data = 32'h77;
    step;
    chk("after_stall_valid", 32'(ex_valid), 32'h1);
    chk("after_stall_op_a", op_a, 32'h77);
    chk("after_stall_dst", 32'(ex_dst), 32'd8);
    exm_wr = 1'b0;

    // hold for three cycles; flush raised during the hold must not act
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    ex_ready = 1'b0;
    id_instr = i_ins(6'h0D, 5'd1, 5'd4, 16'hFFFF);
    step;
    chk("hold1_op_b", op_b, 32'd7);
    id_instr = i_ins(6'h0F, 5'd0, 5'd6, 16'h1234);
    id_rs_data = 32'd9;
    step;
    chk("hold2_opsel", 32'(alu_opsel), 32'b01001);
    flush = 1'b1;
    id_instr = 32'hFC00_0000;
    step;
    chk("hold3_valid", 32'(ex_valid), 32'h1);
    chk("hold3_op_a", op_a, 32'd5);
    chk("hold3_illegal", 32'(ex_illegal), 32'h0);
    ex_ready = 1'b1;
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_wr", 32'(ex_reg_write), 32'h0);
    flush = 1'b0;
    id_rs_data = 32'd5;

    id_instr = 32'hFC00_0000;
    step;
    chk("illegal_valid", 32'(ex_valid), 32'h0);
    chk("illegal_flag", 32'(ex_illegal), 32'h1);
    id_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    step;
    chk("illegal_clear", 32'(ex_illegal), 32'h0);
    chk("post_illegal_valid", 32'(ex_valid), 32'h1);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'h0);
    chk("arst_op_a", op_a, 32'h0);
    chk("arst_opsel", 32'(alu_opsel), 32'h0);
    chk("arst_dst", 32'(ex_dst), 32'h0);
    rst = 1'b0;
    step;
    chk("post_rst_valid", 32'(ex_valid), 32'h1);
    chk("post_rst_op_a", op_a, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
